// File: rtl/constants_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : constants_pkg
//  Description : Shared widths, memory access size codes, sequencer state
//                type and load-extension helper.
//  Revision    : 1.0  initial release
// ============================================================================
package constants_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } mem_seq_state_t;

    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            size,
        input logic                  is_unsigned
    );
        logic [DATA_WIDTH-1:0] ext;
        ext = data;
        case (size)
            MEM_SIZE_BYTE: ext = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, data[7:0]}
                                             : {{(DATA_WIDTH-8){data[7]}}, data[7:0]};
            MEM_SIZE_HALF: ext = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, data[15:0]}
                                             : {{(DATA_WIDTH-16){data[15]}}, data[15:0]};
            default:       ext = data;
        endcase
        return ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_seq_if
//  Description : Request/response handshake and memory bus of the access
//                sequencer. slave = sequencer view, master = environment view.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_seq_if
    import constants_pkg::*;
#(
    parameter int AWIDTH = ADDR_WIDTH,
    parameter int DWIDTH = DATA_WIDTH
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [AWIDTH-1:0] req_addr_i;
    logic [DWIDTH-1:0] req_wdata_i;
    logic              req_store_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;

    logic              resp_valid_o;
    logic [DWIDTH-1:0] resp_rdata_o;
    logic              resp_misaligned_o;

    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [1:0]        mem_size_o;
    logic              mem_unsigned_o;
    logic [DWIDTH-1:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_store_i, req_size_i,
               req_unsigned_i, mem_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_misaligned_o,
               mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
               mem_size_o, mem_unsigned_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_store_i, req_size_i,
               req_unsigned_i, mem_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_misaligned_o,
               mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
               mem_size_o, mem_unsigned_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_seq
//  Description : Turns one pipeline load/store into a single native-size
//                memory beat, or a run of byte beats when misaligned.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_seq
    import constants_pkg::*;
#(
    parameter int AWIDTH = ADDR_WIDTH,
    parameter int DWIDTH = DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_seq_if.slave bus
);

    mem_seq_state_t    r_state;
    logic [1:0]        r_beat;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_store;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [DWIDTH-1:0] r_asm;

    logic              w_misaligned;
    logic [1:0]        w_last_beat;

    always_comb begin
        w_misaligned = 1'b0;
        case (r_size)
            MEM_SIZE_HALF: w_misaligned = r_addr[0];
            MEM_SIZE_WORD: w_misaligned = |r_addr[1:0];
            default:       w_misaligned = 1'b0;
        endcase
        w_last_beat = 2'd0;
        if (w_misaligned)
            w_last_beat = (r_size == MEM_SIZE_HALF) ? 2'd1 : 2'd3;
    end

    // Size code 11 is folded onto word at accept so later logic sees one encoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_store    <= 1'b0;
            r_size     <= MEM_SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_addr     <= bus.req_addr_i;
                        r_wdata    <= bus.req_wdata_i;
                        r_store    <= bus.req_store_i;
                        r_size     <= (bus.req_size_i == 2'b11) ? MEM_SIZE_WORD : bus.req_size_i;
                        r_unsigned <= bus.req_unsigned_i;
                        r_beat     <= 2'd0;
                        r_asm      <= '0;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_store) begin
                        if (w_misaligned)
                            r_asm[{r_beat, 3'b000} +: 8] <= bus.mem_data_i[7:0];
                        else
                            r_asm <= bus.mem_data_i;
                    end
                    if (r_beat == w_last_beat) begin
                        r_beat  <= 2'd0;
                        r_state <= ST_RESP;
                    end else begin
                        r_beat  <= r_beat + 2'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Aligned load data arrives already extended by the memory; only the
    // byte-assembled result needs extending here.
    always_comb begin
        bus.req_ready_o       = (r_state == ST_IDLE);
        bus.resp_valid_o      = (r_state == ST_RESP);
        bus.resp_rdata_o      = '0;
        bus.resp_misaligned_o = 1'b0;
        bus.mem_addr_o        = '0;
        bus.mem_data_o        = '0;
        bus.mem_read_en_o     = 1'b0;
        bus.mem_write_en_o    = 1'b0;
        bus.mem_size_o        = MEM_SIZE_BYTE;
        bus.mem_unsigned_o    = 1'b0;

        if (r_state == ST_ACCESS) begin
            bus.mem_addr_o     = r_addr + AWIDTH'(r_beat);
            bus.mem_read_en_o  = !r_store;
            bus.mem_write_en_o = r_store;
            bus.mem_size_o     = w_misaligned ? MEM_SIZE_BYTE : r_size;
            bus.mem_unsigned_o = w_misaligned | r_unsigned;
            if (r_store)
                bus.mem_data_o = w_misaligned ? (r_wdata >> {r_beat, 3'b000}) : r_wdata;
        end

        if (r_state == ST_RESP) begin
            bus.resp_misaligned_o = w_misaligned;
            if (!r_store)
                bus.resp_rdata_o = w_misaligned
                                 ? DWIDTH'(load_extend(DATA_WIDTH'(r_asm), r_size, r_unsigned))
                                 : r_asm;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_seq
//  Description : Directed self-checking bench for mem_access_seq with a
//                256-byte combinational memory model (low address bits).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_seq;

    logic clk;
    logic rst;
    logic tb_preload;
    int   n_checks;
    int   n_fail;

    logic [7:0]  mem [0:255];
    logic [7:0]  a0;
    logic [31:0] raw;

    mem_access_seq_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    mem_access_seq #(.AWIDTH(32), .DWIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        a0  = bus.mem_addr_o[7:0];
        raw = {mem[8'(a0 + 8'd3)], mem[8'(a0 + 8'd2)], mem[8'(a0 + 8'd1)], mem[a0]};
        case (bus.mem_size_o)
            2'b00:   bus.mem_data_i = bus.mem_unsigned_o ? {24'h0, raw[7:0]}
                                                         : {{24{raw[7]}}, raw[7:0]};
            2'b01:   bus.mem_data_i = bus.mem_unsigned_o ? {16'h0, raw[15:0]}
                                                         : {{16{raw[15]}}, raw[15:0]};
            default: bus.mem_data_i = raw;
        endcase
    end

    always @(posedge clk) begin
        if (tb_preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h40] <= 8'h11; mem[8'h41] <= 8'h22; mem[8'h42] <= 8'h33;
            mem[8'h43] <= 8'h44; mem[8'h44] <= 8'h85; mem[8'h45] <= 8'h66;
            mem[8'hFE] <= 8'hA1; mem[8'hFF] <= 8'hB2; mem[8'h00] <= 8'hC3;
            mem[8'h01] <= 8'hD4;
        end else if (bus.mem_write_en_o) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 0 || (i == 1 && bus.mem_size_o != 2'b00) || bus.mem_size_o[1])
                    mem[8'(bus.mem_addr_o[7:0] + 8'(i))] <= bus.mem_data_o[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic st, input logic [1:0] size, input logic uns,
                           input int nbeats, input logic [1:0] exp_msize,
                           input logic [31:0] exp_rdata, input logic exp_mis);
        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.req_store_i    = st;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            chk("beat_ready",  32'(bus.req_ready_o), 32'd0);
            chk("beat_addr",   bus.mem_addr_o, addr + 32'(k));
            chk("beat_rd",     32'(bus.mem_read_en_o), 32'(!st));
            chk("beat_wr",     32'(bus.mem_write_en_o), 32'(st));
            chk("beat_size",   32'(bus.mem_size_o), 32'(exp_msize));
            chk("beat_uns",    32'(bus.mem_unsigned_o), (nbeats > 1) ? 32'd1 : 32'(uns));
            chk("beat_resp",   32'(bus.resp_valid_o), 32'd0);
            if (st)
                chk("beat_wdata", bus.mem_data_o, (nbeats > 1) ? (wdata >> (8 * k)) : wdata);
            @(posedge clk); #1;
        end
        chk("resp_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("resp_ready", 32'(bus.req_ready_o), 32'd0);
        chk("resp_strobes", {30'h0, bus.mem_read_en_o, bus.mem_write_en_o}, 32'd0);
        chk("resp_rdata", bus.resp_rdata_o, exp_rdata);
        chk("resp_mis",   32'(bus.resp_misaligned_o), 32'(exp_mis));
        @(posedge clk); #1;
        chk("post_ready", 32'(bus.req_ready_o), 32'd1);
        chk("post_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("post_rdata", bus.resp_rdata_o, 32'd0);
        chk("post_mis",   32'(bus.resp_misaligned_o), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst        = 1'b1;
        tb_preload = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.req_store_i    = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("rst_strobes", {30'h0, bus.mem_read_en_o, bus.mem_write_en_o}, 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_rdata", bus.resp_rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        tb_preload = 1'b0;

        // misaligned word load: bytes 22 33 44 85
        run_req(32'h41, 32'h0, 1'b0, 2'b10, 1'b0, 4, 2'b00, 32'h8544_3322, 1'b1);
        // misaligned half load, signed then unsigned
        run_req(32'h43, 32'h0, 1'b0, 2'b01, 1'b0, 2, 2'b00, 32'hFFFF_8544, 1'b1);
        run_req(32'h43, 32'h0, 1'b0, 2'b01, 1'b1, 2, 2'b00, 32'h0000_8544, 1'b1);
        // aligned word load (size code 11 treated as word)
        run_req(32'h44, 32'h0, 1'b0, 2'b10, 1'b0, 1, 2'b10, 32'h0000_6685, 1'b0);
        run_req(32'h44, 32'h0, 1'b0, 2'b11, 1'b0, 1, 2'b10, 32'h0000_6685, 1'b0);
        // aligned byte signed, aligned half unsigned
        run_req(32'h44, 32'h0, 1'b0, 2'b00, 1'b0, 1, 2'b00, 32'hFFFF_FF85, 1'b0);
        run_req(32'h44, 32'h0, 1'b0, 2'b01, 1'b1, 1, 2'b01, 32'h0000_6685, 1'b0);
        // wrap-around at the top of the address space
        run_req(32'hFFFF_FFFE, 32'h0, 1'b0, 2'b10, 1'b0, 4, 2'b00, 32'hD4C3_B2A1, 1'b1);

        // misaligned word store then readback
        run_req(32'h42, 32'hAABB_CCDD, 1'b1, 2'b10, 1'b0, 4, 2'b00, 32'h0, 1'b1);
        chk("st_mem42", 32'(mem[8'h42]), 32'hDD);
        chk("st_mem43", 32'(mem[8'h43]), 32'hCC);
        chk("st_mem44", 32'(mem[8'h44]), 32'hBB);
        chk("st_mem45", 32'(mem[8'h45]), 32'hAA);
        chk("st_mem41", 32'(mem[8'h41]), 32'h22);
        run_req(32'h42, 32'h0, 1'b0, 2'b10, 1'b0, 4, 2'b00, 32'hAABB_CCDD, 1'b1);

        // aligned word store
        run_req(32'h48, 32'h1234_5678, 1'b1, 2'b10, 1'b0, 1, 2'b10, 32'h0, 1'b0);
        chk("ast_mem48", {mem[8'h4B], mem[8'h4A], mem[8'h49], mem[8'h48]}, 32'h1234_5678);

        // store aborted by reset after two committed beats
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = 32'h41;
        bus.req_wdata_i    = 32'h9988_7766;
        bus.req_store_i    = 1'b1;
        bus.req_size_i     = 2'b10;
        bus.req_unsigned_i = 1'b0;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_beat2_wr", 32'(bus.mem_write_en_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.req_ready_o), 32'd1);
        chk("abort_wr",    32'(bus.mem_write_en_o), 32'd0);
        chk("abort_valid", 32'(bus.resp_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("abort_ready2", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort_noresp", 32'(bus.resp_valid_o), 32'd0);
            chk("abort_nostrobe", {30'h0, bus.mem_read_en_o, bus.mem_write_en_o}, 32'd0);
        end
        chk("abort_mem41", 32'(mem[8'h41]), 32'h66);
        chk("abort_mem42", 32'(mem[8'h42]), 32'h77);
        chk("abort_mem43", 32'(mem[8'h43]), 32'hCC);
        chk("abort_mem44", 32'(mem[8'h44]), 32'hBB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
